// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - request/grant and write-port bundle for rf_write_arbiter
// master = writeback sources side, slave = arbiter side.
interface rf_write_arbiter_if #(
  parameter int REGI_BITS = 4,
  parameter int REGI_SIZE = 16,
  parameter int NUM_REQ   = 3
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_lock;
  logic [NUM_REQ*REGI_BITS-1:0] req_addr;
  logic [NUM_REQ*REGI_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         we3;
  logic [REGI_BITS-1:0]         wa3;
  logic [REGI_SIZE-1:0]         wd3;
  logic [IDW-1:0]               grant_id;
  logic                         locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, we3, wa3, wd3, grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, we3, wa3, wd3, grant_id, locked
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter with burst lock for the register file write port
// Optional sticky filtered-write flag (err/err_clr) under RF_ARB_ERR_EN.
module rf_write_arbiter #(
  parameter int REGI_BITS = 4,
  parameter int REGI_SIZE = 16,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  rf_write_arbiter_if.slave bus
`ifdef RF_ARB_ERR_EN
  ,
  input  logic              err_clr,
  output logic              err
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = 4;
  localparam logic [IDW-1:0]       LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BW-1:0]        BURST_CAP = BW'(MAX_BURST);
  localparam logic [REGI_BITS-1:0] PC_ADDR   = REGI_BITS'(REGI_SIZE - 1);

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 we3_q, we3_d;
  logic [REGI_BITS-1:0] wa3_q, wa3_d;
  logic [REGI_SIZE-1:0] wd3_q, wd3_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;

  logic [REGI_BITS-1:0] addr_a [NUM_REQ];
  logic [REGI_SIZE-1:0] data_a [NUM_REQ];

  logic                 rr_found;
  logic [IDW-1:0]       rr_win;
  logic [IDW-1:0]       cand;
  logic                 gnt_valid;
  logic [IDW-1:0]       gnt_idx;
  logic [BW-1:0]        beat_inc;
  logic [REGI_BITS-1:0] sel_addr;
  logic [REGI_SIZE-1:0] sel_data;
  logic                 gnt_filt;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = bus.req_addr[i*REGI_BITS +: REGI_BITS];
      data_a[i] = bus.req_data[i*REGI_SIZE +: REGI_SIZE];
    end
  end

  // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid source wins.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
      cand = next_id(cand);
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    beat_d    = beat_q;
    gnt_valid = 1'b0;
    gnt_idx   = rr_win;
    beat_inc  = beat_q + 1'b1;
    if (!stall) begin
      case (state_q)
        ST_ARB: begin
          if (rr_found) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_win;
            rr_ptr_d  = next_id(rr_win);
            if (bus.req_lock[rr_win] && (MAX_BURST > 1)) begin
              state_d = ST_LOCKED;
              owner_d = rr_win;
              beat_d  = BW'(1);
            end
          end
        end
        ST_LOCKED: begin
          // Owner dropping valid releases the port without a grant this cycle.
          if (bus.req_valid[owner_q]) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
            if (!bus.req_lock[owner_q] || (beat_inc >= BURST_CAP)) begin
              state_d  = ST_ARB;
              rr_ptr_d = next_id(owner_q);
              beat_d   = '0;
            end else begin
              beat_d = beat_inc;
            end
          end else begin
            state_d  = ST_ARB;
            rr_ptr_d = next_id(owner_q);
            beat_d   = '0;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && gnt_valid) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // r0 and the PC slot still handshake, but never reach the write port.
  always_comb begin
    sel_addr   = addr_a[gnt_idx];
    sel_data   = data_a[gnt_idx];
    gnt_filt   = (sel_addr == '0) || (sel_addr == PC_ADDR);
    we3_d      = gnt_valid && !gnt_filt;
    wa3_d      = we3_d ? sel_addr : wa3_q;
    wd3_d      = we3_d ? sel_data : wd3_q;
    grant_id_d = gnt_valid ? gnt_idx : grant_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_q     <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.we3      = we3_q;
  assign bus.wa3      = wa3_q;
  assign bus.wd3      = wd3_q;
  assign bus.grant_id = grant_id_q;
  assign bus.locked   = (state_q == ST_LOCKED);

`ifdef RF_ARB_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (gnt_valid && gnt_filt) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
// Covers err/err_clr as well when built with RF_ARB_ERR_EN.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
`ifdef RF_ARB_ERR_EN
  logic err;
  logic err_clr;
`endif

  rf_write_arbiter_if #(.REGI_BITS(4), .REGI_SIZE(16), .NUM_REQ(3)) bus ();

  rf_write_arbiter #(
    .REGI_BITS(4), .REGI_SIZE(16), .NUM_REQ(3), .MAX_BURST(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .bus     (bus)
`ifdef RF_ARB_ERR_EN
    ,
    .err_clr (err_clr),
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [3:0]  a;
    logic [15:0] d;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write-port beat must match the oldest expected beat, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.we3) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected_we3", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_due_cycle", 32'(cnt), 32'(e.due));
          chk("wb_wa3", 32'(bus.wa3), 32'(e.a));
          chk("wb_wd3", 32'(bus.wd3), 32'(e.d));
          chk("wb_grant_id", 32'(bus.grant_id), 32'(e.id));
        end
      end else if (sb.size() > 0 && sb[0].due <= cnt) begin
        e = sb.pop_front();
        chk("wb_missing_we3", 32'd0, 32'd1);
      end
    end
  end

  task automatic set_src(input int i, input logic v, input logic l,
                         input logic [3:0] a, input logic [15:0] d);
    bus.req_valid[i]      = v;
    bus.req_lock[i]       = l;
    bus.req_addr[i*4 +: 4]   = a;
    bus.req_data[i*16 +: 16] = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  // One clock: check ready/locked mid-cycle, queue the expected write, advance past posedge.
  task automatic cyc(input string nm, input logic [2:0] rdy, input logic lk,
                     input logic wr, input logic [3:0] a, input logic [15:0] d, input int id);
    exp_t e;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({nm, "_locked"}, 32'(bus.locked), 32'(lk));
    if (wr) begin
      e.due = cnt + 1;
      e.a   = a;
      e.d   = d;
      e.id  = id;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
`ifdef RF_ARB_ERR_EN
    err_clr = 1'b0;
`endif
    clr_all();
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 1'b0, 4'(i + 1), 16'h1234);
    #2;
    chk("rst_we3", 32'(bus.we3), 32'd0);
    chk("rst_wa3", 32'(bus.wa3), 32'd0);
    chk("rst_wd3", 32'(bus.wd3), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef RF_ARB_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    clr_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin, rr_ptr starts at 0
    set_src(0, 1'b1, 1'b0, 4'd1, 16'h1111);
    set_src(1, 1'b1, 1'b0, 4'd2, 16'h2222);
    set_src(2, 1'b1, 1'b0, 4'd3, 16'h3333);
    cyc("rr0", 3'b001, 1'b0, 1'b1, 4'd1, 16'h1111, 0);
    cyc("rr1", 3'b010, 1'b0, 1'b1, 4'd2, 16'h2222, 1);
    cyc("rr2", 3'b100, 1'b0, 1'b1, 4'd3, 16'h3333, 2);
    cyc("rr3", 3'b001, 1'b0, 1'b1, 4'd1, 16'h1111, 0);
    clr_all();
    cyc("rr_idle", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);

    // Burst cap: rr_ptr=1, source 1 locks for MAX_BURST beats then source 0 gets one
    set_src(0, 1'b1, 1'b0, 4'd4, 16'h0A0A);
    set_src(1, 1'b1, 1'b1, 4'd5, 16'h5555);
    cyc("burst1", 3'b010, 1'b0, 1'b1, 4'd5, 16'h5555, 1);
    cyc("burst2", 3'b010, 1'b1, 1'b1, 4'd5, 16'h5555, 1);
    cyc("burst3", 3'b010, 1'b1, 1'b1, 4'd5, 16'h5555, 1);
    cyc("burst4", 3'b010, 1'b1, 1'b1, 4'd5, 16'h5555, 1);
    cyc("burst_other", 3'b001, 1'b0, 1'b1, 4'd4, 16'h0A0A, 0);
    cyc("burst_again", 3'b010, 1'b0, 1'b1, 4'd5, 16'h5555, 1);
    clr_all();
    cyc("burst_drop", 3'b000, 1'b1, 1'b0, 4'd0, 16'h0, 0);
    cyc("burst_idle", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);

    // Filtered addresses: rr_ptr=2, handshakes but no write
    set_src(2, 1'b1, 1'b0, 4'd0, 16'hBEEF);
    cyc("filt_r0", 3'b100, 1'b0, 1'b0, 4'd0, 16'h0, 0);
`ifdef RF_ARB_ERR_EN
    chk("err_set", 32'(err), 32'd1);
`endif
    set_src(2, 1'b1, 1'b0, 4'd15, 16'hBEEF);
    cyc("filt_pc", 3'b100, 1'b0, 1'b0, 4'd0, 16'h0, 0);
    clr_all();
`ifdef RF_ARB_ERR_EN
    err_clr = 1'b1;
`endif
    cyc("filt_idle", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);
`ifdef RF_ARB_ERR_EN
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
`endif
    chk("filt_wa3_hold", 32'(bus.wa3), 32'd5);
    chk("filt_wd3_hold", 32'(bus.wd3), 32'h5555);
    chk("filt_we3_low", 32'(bus.we3), 32'd0);

    // Stall: rr_ptr=0, sources 0 and 1 waiting
    set_src(0, 1'b1, 1'b0, 4'd6, 16'h6666);
    set_src(1, 1'b1, 1'b0, 4'd7, 16'h7777);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);
    stall = 1'b0;
    cyc("stall_rel0", 3'b001, 1'b0, 1'b1, 4'd6, 16'h6666, 0);
    cyc("stall_rel1", 3'b010, 1'b0, 1'b1, 4'd7, 16'h7777, 1);
    cyc("stall_rel2", 3'b001, 1'b0, 1'b1, 4'd6, 16'h6666, 0);
    clr_all();
    cyc("stall_idle", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);

    // Owner drop: rr_ptr=1, source 0 locks then releases valid
    set_src(0, 1'b1, 1'b1, 4'd8, 16'h8888);
    cyc("drop_lock", 3'b001, 1'b0, 1'b1, 4'd8, 16'h8888, 0);
    set_src(0, 1'b0, 1'b1, 4'd8, 16'h8888);
    set_src(2, 1'b1, 1'b0, 4'd9, 16'h9999);
    cyc("drop_gap", 3'b000, 1'b1, 1'b0, 4'd0, 16'h0, 0);
    cyc("drop_next", 3'b100, 1'b0, 1'b1, 4'd9, 16'h9999, 2);
    clr_all();

    // Async reset mid-burst: rr_ptr=0, source 1 locks
    set_src(1, 1'b1, 1'b1, 4'd10, 16'hAAAA);
    cyc("rstb1", 3'b010, 1'b0, 1'b1, 4'd10, 16'hAAAA, 1);
    cyc("rstb2", 3'b010, 1'b1, 1'b1, 4'd10, 16'hAAAA, 1);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rstmid_we3", 32'(bus.we3), 32'd0);
    chk("rstmid_locked", 32'(bus.locked), 32'd0);
    chk("rstmid_ready", 32'(bus.req_ready), 32'd0);
    set_src(0, 1'b1, 1'b0, 4'd11, 16'hBBBB);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rst_first", 3'b001, 1'b0, 1'b1, 4'd11, 16'hBBBB, 0);
    clr_all();
    cyc("end_idle0", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);
    cyc("end_idle1", 3'b000, 1'b0, 1'b0, 4'd0, 16'h0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
